register_file_2r1w: RTL and testbench

REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

---
 rtl/register_file_pkg.sv | 9 +
 rtl/rf_read_port.sv | 34 +++
 rtl/register_file_2r1w.sv | 102 ++++++++++
 tb/tb_register_file_2r1w.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared types for the 2R1W register file
package register_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - registered read port with write-first bypass and zero-entry masking
module rf_read_port #(
  parameter int bits       = 8,
  parameter int addr_width = 2,
  parameter bit zero_reg   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [addr_width-1:0] raddr,
  input  logic [bits-1:0]       rdata,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] waddr,
  input  logic [bits-1:0]       wdata,
  output logic [bits-1:0]       q
);

  logic [bits-1:0] q_next;

  // Masking wins over bypass so entry 0 reads as zero even during a same-edge write.
  always_comb begin
    q_next = rdata;
    if (wr_en && (waddr == raddr)) q_next = wdata;
    if (zero_reg && (raddr == '0)) q_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/register_file_2r1w.sv
// rtl/register_file_2r1w.sv - flop-based two-read one-write register file with bulk clear sweep
module register_file_2r1w
  import register_file_pkg::*;
#(
  parameter int bits       = 8,
  parameter int addr_width = 2,
  parameter bit zero_reg   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [bits-1:0]       wdata,
  input  logic [addr_width-1:0] raddr_a,
  input  logic [addr_width-1:0] raddr_b,
  output logic [bits-1:0]       qa,
  output logic [bits-1:0]       qb,
  input  logic                  clr,
  output logic                  busy,
  output logic                  clr_done,
  output logic                  wr_drop
);

  localparam int depth = 1 << addr_width;

  logic [bits-1:0]       mem [depth];
  clr_state_t            state;
  logic [addr_width-1:0] cnt;
  logic                  wr_accept;
  logic [bits-1:0]       rdata_a;
  logic [bits-1:0]       rdata_b;

  // Writes to a hard-wired zero entry are silently discarded, not reported as drops.
  assign wr_accept = we && !busy && !(zero_reg && (waddr == '0));
  assign rdata_a   = mem[raddr_a];
  assign rdata_b   = mem[raddr_b];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      wr_drop  <= we && busy;
      case (state)
        IDLE: begin
          if (wr_accept) mem[waddr] <= wdata;
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          cnt      <= cnt + 1'b1;
          if (cnt == '1) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rf_read_port #(
    .bits       (bits),
    .addr_width (addr_width),
    .zero_reg   (zero_reg)
  ) u_port_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (raddr_a),
    .rdata (rdata_a),
    .wr_en (wr_accept),
    .waddr (waddr),
    .wdata (wdata),
    .q     (qa)
  );

  rf_read_port #(
    .bits       (bits),
    .addr_width (addr_width),
    .zero_reg   (zero_reg)
  ) u_port_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (raddr_b),
    .rdata (rdata_b),
    .wr_en (wr_accept),
    .waddr (waddr),
    .wdata (wdata),
    .q     (qb)
  );

endmodule

// File: tb/tb_register_file_2r1w.sv
// tb/tb_register_file_2r1w.sv - bench for register_file_2r1w, plain and zero_reg instances side by side
module tb_register_file_2r1w;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       we = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] waddr = 2'd0;
  logic [1:0] raddr_a = 2'd0;
  logic [1:0] raddr_b = 2'd0;
  logic [7:0] wdata = 8'h00;

  logic [7:0] qa0, qb0, qa1, qb1;
  logic       busy0, done0, drop0, busy1, done1, drop1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  register_file_2r1w #(.bits(8), .addr_width(2), .zero_reg(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .qa(qa0), .qb(qb0),
    .clr(clr), .busy(busy0), .clr_done(done0), .wr_drop(drop0)
  );

  register_file_2r1w #(.bits(8), .addr_width(2), .zero_reg(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .qa(qa1), .qb(qb1),
    .clr(clr), .busy(busy1), .clr_done(done1), .wr_drop(drop1)
  );

  // Reference: index 0 is the plain instance, index 1 the zero_reg instance.
  logic [7:0] m_mem [2][4];
  bit         m_busy;
  int         m_sweep;
  logic [7:0] e_qa [2];
  logic [7:0] e_qb [2];
  bit         e_done;
  bit         e_drop;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 4; i++) m_mem[z][i] = 8'h00;
      e_qa[z] = 8'h00;
      e_qb[z] = 8'h00;
    end
    m_busy  = 1'b0;
    m_sweep = 0;
    e_done  = 1'b0;
    e_drop  = 1'b0;
  endtask

  task automatic compare_all(input string where);
    check($sformatf("%s qa0", where), qa0, e_qa[0]);
    check($sformatf("%s qb0", where), qb0, e_qb[0]);
    check($sformatf("%s qa1", where), qa1, e_qa[1]);
    check($sformatf("%s qb1", where), qb1, e_qb[1]);
    check($sformatf("%s busy0", where), {7'd0, busy0}, {7'd0, m_busy});
    check($sformatf("%s busy1", where), {7'd0, busy1}, {7'd0, m_busy});
    check($sformatf("%s done0", where), {7'd0, done0}, {7'd0, e_done});
    check($sformatf("%s done1", where), {7'd0, done1}, {7'd0, e_done});
    check($sformatf("%s drop0", where), {7'd0, drop0}, {7'd0, e_drop});
    check($sformatf("%s drop1", where), {7'd0, drop1}, {7'd0, e_drop});
  endtask

  task automatic set_in(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                        input logic [1:0] ra, input logic [1:0] rb, input logic c);
    we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb; clr = c;
  endtask

  // One clock edge: predict from the pre-edge picture, then compare 1 ns after the edge.
  task automatic cycle(input string where);
    logic [7:0] nqa [2];
    logic [7:0] nqb [2];
    bit         acc [2];
    for (int z = 0; z < 2; z++) begin
      acc[z] = we && !m_busy && !(z == 1 && waddr == 2'd0);
      if (z == 1 && raddr_a == 2'd0)      nqa[z] = 8'h00;
      else if (acc[z] && waddr == raddr_a) nqa[z] = wdata;
      else                                 nqa[z] = m_mem[z][raddr_a];
      if (z == 1 && raddr_b == 2'd0)      nqb[z] = 8'h00;
      else if (acc[z] && waddr == raddr_b) nqb[z] = wdata;
      else                                 nqb[z] = m_mem[z][raddr_b];
    end
    e_drop = we && m_busy;
    e_done = 1'b0;
    if (m_busy) begin
      for (int z = 0; z < 2; z++) m_mem[z][m_sweep] = 8'h00;
      if (m_sweep == 3) begin
        m_busy = 1'b0;
        e_done = 1'b1;
      end
      m_sweep = (m_sweep + 1) % 4;
    end else begin
      for (int z = 0; z < 2; z++) if (acc[z]) m_mem[z][waddr] = wdata;
      if (clr) begin
        m_busy  = 1'b1;
        m_sweep = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int z = 0; z < 2; z++) begin
      e_qa[z] = nqa[z];
      e_qb[z] = nqb[z];
    end
    compare_all(where);
  endtask

  // Called 1 ns after an edge; reset asserts and releases between edges.
  task automatic async_reset(input string where);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(where);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    compare_all("reset");
    #6 rst_n = 1'b1;

    // Basic write then registered read
    set_in(1'b1, 2'd2, 8'hA5, 2'd0, 2'd0, 1'b0); cycle("wr2");
    set_in(1'b0, 2'd0, 8'h00, 2'd2, 2'd1, 1'b0); cycle("rd2");
    check("basic qa", qa0, 8'hA5);
    check("basic qb", qb0, 8'h00);

    // Same-edge bypass on both ports
    set_in(1'b1, 2'd3, 8'h3C, 2'd3, 2'd3, 1'b0); cycle("byp");
    check("bypass qa", qa0, 8'h3C);
    check("bypass qb", qb0, 8'h3C);

    // Fill, then clear sweep; a clr during the sweep must not restart it
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'(i), 8'(8'h11 * (i + 1)), 2'(i), 2'd0, 1'b0);
      cycle("fill");
    end
    set_in(1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b1); cycle("clr0");
    check("clr busy start", {7'd0, busy0}, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b0, 2'd0, 8'h00, 2'(i - 1), 2'd3, i == 2);
      cycle("sweep");
      check($sformatf("sweep%0d busy", i), {7'd0, busy0}, (i < 4) ? 8'h01 : 8'h00);
      check($sformatf("sweep%0d done", i), {7'd0, done0}, (i == 4) ? 8'h01 : 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 2'd0, 8'h00, 2'(i), 2'(3 - i), 1'b0); cycle("postclr");
      check("postclr qa", qa0, 8'h00);
    end

    // Write during busy is refused
    set_in(1'b1, 2'd1, 8'h5A, 2'd0, 2'd0, 1'b1); cycle("wr1clr");
    set_in(1'b1, 2'd1, 8'hFF, 2'd1, 2'd1, 1'b0); cycle("busywr");
    check("drop pulse", {7'd0, drop0}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 2'd0, 8'h00, 2'd1, 2'd2, 1'b0); cycle("drain");
    end
    set_in(1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 1'b0); cycle("rb1");
    check("dropped readback", qa0, 8'h00);

    // zero_reg: entry 0 discards writes and reads as zero
    set_in(1'b1, 2'd0, 8'h77, 2'd0, 2'd0, 1'b0); cycle("z0wr");
    check("zreg bypass qa", qa1, 8'h00);
    set_in(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b0); cycle("z0rd");
    check("zreg qa", qa1, 8'h00);
    check("zreg drop", {7'd0, drop1}, 8'h00);
    check("plain qa0 entry0", qa0, 8'h77);

    // Reset during the second sweep cycle aborts the clear
    set_in(1'b1, 2'd2, 8'h99, 2'd2, 2'd2, 1'b1); cycle("clrR");
    set_in(1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 1'b0); cycle("sw1");
    async_reset("midreset");
    check("midreset busy", {7'd0, busy0}, 8'h00);
    check("midreset qa", qa0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 2'd0, 8'h00, 2'd2, 2'd0, 1'b0); cycle("afterR");
    end
    set_in(1'b1, 2'd3, 8'hC3, 2'd0, 2'd0, 1'b0); cycle("afterRwr");
    set_in(1'b0, 2'd0, 8'h00, 2'd3, 2'd3, 1'b0); cycle("afterRrd");
    check("afterR qa", qa0, 8'hC3);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 15) == 0);
      cycle("rand");
      if ($urandom_range(0, 149) == 0) async_reset("randreset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
